// File: rtl/cnn_dma_pkg.sv
// Shared types and default sizes for the layer-controller DMA responder.
package cnn_dma_pkg;

  localparam int K_DEF  = 5;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    RD_WIN  = 2'd0,
    WR_WORD = 2'd1,
    LD_FILT = 2'd2,
    LD_BIAS = 2'd3
  } dma_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER    = 2'd1,
    S_FB_PUSH = 2'd2,
    S_DONE    = 2'd3
  } dma_state_e;

  // Operations that move exactly one word.
  function automatic logic op_is_single(input dma_op_e op);
    return (op == WR_WORD) || (op == LD_BIAS);
  endfunction

  // Operations that end with a filter-buffer push.
  function automatic logic op_pushes_fb(input dma_op_e op);
    return (op == LD_FILT) || (op == LD_BIAS);
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Address sequencer for the DMA responder: walks a KxK window using a
// row-start accumulator (no multiplier), or issues a single address.
// All address arithmetic wraps modulo 2^AW.
module dma_addr_gen #(
  parameter int K  = 5,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic          single,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] row_start;
  logic [AW-1:0] stride_reg;
  logic          single_reg;

  // Load a new walk, or advance one word on each acknowledged access.
  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      row_start  <= '0;
      addr       <= '0;
      stride_reg <= '0;
      single_reg <= 1'b0;
    end else if (load) begin
      row        <= '0;
      col        <= '0;
      row_start  <= base;
      addr       <= base;
      stride_reg <= stride;
      single_reg <= single;
    end else if (step && !last) begin
      if (col == LAST_IDX) begin
        col       <= '0;
        row       <= row + CW'(1);
        row_start <= row_start + stride_reg;
        addr      <= row_start + stride_reg;
      end else begin
        col  <= col + CW'(1);
        addr <= addr + AW'(1);
      end
    end
  end

  assign last = single_reg || ((row == LAST_IDX) && (col == LAST_IDX));

endmodule

// File: rtl/window_dma_responder.sv
// Responder side of the layer controller's start/finish DMA handshake.
// Runs one request at a time: KxK window read, single word write, filter
// load or bias load, as a sequence of single-word RAM accesses.
// Optional feature macro: DMA_PERF_CNT_EN adds saturating busy/stall counters.
module window_dma_responder
  import cnn_dma_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_start,
  input  logic [1:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [AW-1:0]     req_stride,
  input  logic [15:0]       req_index,
  input  logic [DW-1:0]     req_wdata,
  output logic              req_finish,
  output logic [K*K*DW-1:0] win_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ack,
  output logic              fb_we,
  output logic              fb_sel,
  output logic [15:0]       fb_index,
  output logic [K*K*DW-1:0] fb_filter,
`ifdef DMA_PERF_CNT_EN
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall,
`endif
  output logic [DW-1:0]     fb_bias
);

  localparam int N     = K * K;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  dma_state_e           state;
  dma_op_e              op_reg;
  logic [15:0]          index_reg;
  logic [DW-1:0]        wdata_reg;
  logic [CNT_W-1:0]     word_cnt;
  logic [N-1:0][DW-1:0] win_reg;
  logic [N-1:0][DW-1:0] filt_reg;
  logic [DW-1:0]        bias_reg;
  logic                 mem_en_reg;
  logic                 mem_we_reg;
  logic                 finish_reg;
  logic                 fb_we_reg;

  dma_op_e       req_op_e;
  logic          gen_load;
  logic          gen_step;
  logic [AW-1:0] gen_base;
  logic [AW-1:0] gen_stride;
  logic          gen_last;

  assign req_op_e   = dma_op_e'(req_op);
  assign gen_load   = (state == S_IDLE) && req_start;
  assign gen_step   = (state == S_XFER) && mem_ack;
  // Bias slot address is folded into the base; filters are a contiguous KxK run.
  assign gen_base   = (req_op_e == LD_BIAS) ? (req_addr + AW'(req_index)) : req_addr;
  assign gen_stride = (req_op_e == LD_FILT) ? AW'(K) : req_stride;

  dma_addr_gen #(.K(K), .AW(AW)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (gen_load),
    .step   (gen_step),
    .base   (gen_base),
    .stride (gen_stride),
    .single (op_is_single(req_op_e)),
    .addr   (mem_addr),
    .last   (gen_last)
  );

  // Request FSM with registered handshake, memory and filter-buffer strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_reg     <= RD_WIN;
      index_reg  <= '0;
      wdata_reg  <= '0;
      word_cnt   <= '0;
      win_reg    <= '0;
      filt_reg   <= '0;
      bias_reg   <= '0;
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      finish_reg <= 1'b0;
      fb_we_reg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_start) begin
            op_reg     <= req_op_e;
            index_reg  <= req_index;
            wdata_reg  <= req_wdata;
            word_cnt   <= '0;
            mem_en_reg <= 1'b1;
            mem_we_reg <= (req_op_e == WR_WORD);
            state      <= S_XFER;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            case (op_reg)
              RD_WIN:  win_reg[word_cnt]  <= mem_rdata;
              LD_FILT: filt_reg[word_cnt] <= mem_rdata;
              LD_BIAS: bias_reg           <= mem_rdata;
              default: ;
            endcase
            word_cnt <= word_cnt + CNT_W'(1);
            if (gen_last) begin
              mem_en_reg <= 1'b0;
              mem_we_reg <= 1'b0;
              if (op_pushes_fb(op_reg)) begin
                fb_we_reg <= 1'b1;
                state     <= S_FB_PUSH;
              end else begin
                finish_reg <= 1'b1;
                state      <= S_DONE;
              end
            end
          end
        end
        S_FB_PUSH: begin
          fb_we_reg  <= 1'b0;
          finish_reg <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          // Leaving only on a low start guarantees no retrigger on a held start.
          if (!req_start) begin
            finish_reg <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_finish = finish_reg;
  assign mem_en     = mem_en_reg;
  assign mem_we     = mem_we_reg;
  assign mem_wdata  = wdata_reg;
  assign win_data   = win_reg;
  assign fb_we      = fb_we_reg;
  assign fb_sel     = (op_reg == LD_BIAS);
  assign fb_index   = index_reg;
  assign fb_filter  = filt_reg;
  assign fb_bias    = bias_reg;

`ifdef DMA_PERF_CNT_EN
  // Saturating activity counters: busy outside IDLE, stall while waiting on memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_busy != '1))
        perf_busy <= perf_busy + 32'd1;
      if ((state == S_XFER) && !mem_ack && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_dma_responder.sv
// Self-checking bench for window_dma_responder with a behavioural RAM,
// configurable ack latency and scoreboard queues of expected accesses.
module tb_window_dma_responder;

  localparam int K  = 5;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = K * K;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_start;
  logic [1:0]        req_op;
  logic [AW-1:0]     req_addr;
  logic [AW-1:0]     req_stride;
  logic [15:0]       req_index;
  logic [DW-1:0]     req_wdata;
  logic              req_finish;
  logic [N*DW-1:0]   win_data;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;
  logic              fb_we;
  logic              fb_sel;
  logic [15:0]       fb_index;
  logic [N*DW-1:0]   fb_filter;
  logic [DW-1:0]     fb_bias;
`ifdef DMA_PERF_CNT_EN
  logic [31:0]       perf_busy;
  logic [31:0]       perf_stall;
`endif

  always #5 clk = ~clk;

  window_dma_responder #(.K(K), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_start  (req_start),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_stride (req_stride),
    .req_index  (req_index),
    .req_wdata  (req_wdata),
    .req_finish (req_finish),
    .win_data   (win_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .fb_we      (fb_we),
    .fb_sel     (fb_sel),
    .fb_index   (fb_index),
    .fb_filter  (fb_filter),
`ifdef DMA_PERF_CNT_EN
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall),
`endif
    .fb_bias    (fb_bias)
  );

  // ---------------- memory model and monitors ----------------
  logic [DW-1:0] ram [0:65535];
  int ack_delay = 0;
  int wait_cnt  = 0;

  assign mem_rdata = ram[mem_addr];
  assign mem_ack   = mem_en && (wait_cnt == ack_delay);

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            cycles;
    bit            stable;
  } acc_t;

  typedef struct {
    logic            sel;
    logic [15:0]     index;
    logic [N*DW-1:0] filter;
    logic [DW-1:0]   bias;
  } fb_t;

  acc_t          obs_q[$];
  fb_t           fb_q[$];
  logic [AW-1:0] exp_q[$];

  logic [AW-1:0] hold_addr;
  logic          hold_we;
  logic [DW-1:0] hold_wdata;
  int            hold_cycles = 0;
  bit            hold_stable;

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0;
      hold_cycles = 0;
    end else begin
      if (mem_en) begin
        if (hold_cycles == 0) begin
          hold_addr   = mem_addr;
          hold_we     = mem_we;
          hold_wdata  = mem_wdata;
          hold_stable = 1'b1;
        end else if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) begin
          hold_stable = 1'b0;
        end
        hold_cycles++;
        if (mem_ack) begin
          if (mem_we) ram[mem_addr] = mem_wdata;
          obs_q.push_back('{hold_addr, hold_we, hold_wdata, hold_cycles, hold_stable});
          hold_cycles = 0;
          wait_cnt <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
      if (fb_we) fb_q.push_back('{fb_sel, fb_index, fb_filter, fb_bias});
    end
  end

  // ---------------- helpers ----------------
  int errors = 0;
  int checks = 0;
  int pattern = 0;
  logic [N*DW-1:0] last_win;

  function automatic logic [DW-1:0] pat(input int p, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (p == 0) v = a;
    else        v = DW'(a * 16'd3 + 16'd7);
    return v;
  endfunction

  task automatic fill_ram(input int p);
    pattern = p;
    for (int i = 0; i < 65536; i++) ram[i] = pat(p, AW'(i));
  endtask

  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] stride,
                         input logic [15:0] index, input logic [DW-1:0] wdata, input bit hold,
                         output int lat, output bit ok);
    @(negedge clk);
    req_op = op; req_addr = addr; req_stride = stride; req_index = index; req_wdata = wdata;
    req_start = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      lat++;
      if (req_finish) begin
        ok = 1'b1;
        break;
      end
    end
    if (!hold) req_start = 1'b0;
  endtask

  // Pop expected addresses and compare to observed accesses (reads).
  task automatic check_reads(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d accesses expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t a;
      logic [AW-1:0] e;
      a = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a.addr !== e || a.we !== 1'b0) begin
        errors++;
        $display("FAIL %s_addr: got addr %h we %b expected addr %h we 0", name, a.addr, a.we, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2*N*DW+3*DW+AW+16+5-1:0] all_out;
    reset = 1'b1; req_start = 1'b0; req_op = '0; req_addr = '0; req_stride = '0;
    req_index = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    all_out = {req_finish, mem_en, mem_we, mem_addr, mem_wdata, fb_we, fb_sel, fb_index,
               fb_filter, fb_bias, win_data};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d set bits expected 0", $countones(all_out));
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rd_win();
    int lat; bit ok;
    logic [N*DW-1:0] exp_win;
    fill_ram(0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        exp_q.push_back(AW'(100 + 32 * r + c));
        exp_win[(r*K+c)*DW +: DW] = DW'(100 + 32 * r + c);
      end
    run_req(2'd0, 16'd100, 16'd32, 16'd0, 16'd0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != 26) begin
      errors++;
      $display("FAIL rd_win_latency: got %0d (finished=%0d) expected 26", lat, ok);
    end
    check_reads("rd_win");
    checks++;
    if (win_data !== exp_win) begin
      errors++;
      $display("FAIL rd_win_data: got %h expected %h", win_data, exp_win);
    end
    last_win = exp_win;
    $display("rd_win addr=100 stride=32 latency=%0d", lat);
  endtask

  task automatic test_wr_word();
    int lat; bit ok; int held;
    acc_t a;
    ack_delay = 3;
    run_req(2'd1, 16'h1234, 16'd0, 16'd0, 16'hBEEF, 1'b1, lat, ok);
    checks++;
    if (!ok || lat != 5) begin
      errors++;
      $display("FAIL wr_word_latency: got %0d (finished=%0d) expected 5", lat, ok);
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL wr_word_count: got %0d accesses expected 1", obs_q.size());
    end else begin
      a = obs_q.pop_front();
      checks++;
      if (a.addr !== 16'h1234 || a.we !== 1'b1 || a.wdata !== 16'hBEEF || a.cycles != 4 || !a.stable) begin
        errors++;
        $display("FAIL wr_word_access: got addr %h we %b wdata %h cycles %0d stable %0d expected 1234 1 beef 4 1",
                 a.addr, a.we, a.wdata, a.cycles, a.stable);
      end
    end
    obs_q.delete();
    checks++;
    if (ram[16'h1234] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_word_ram: got %h expected beef", ram[16'h1234]);
    end
    held = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (req_finish === 1'b1) held++;
    end
    checks++;
    if (held != 3) begin
      errors++;
      $display("FAIL wr_word_finish_held: got %0d cycles expected 3", held);
    end
    req_start = 1'b0;
    @(negedge clk);
    checks++;
    if (req_finish !== 1'b0) begin
      errors++;
      $display("FAIL wr_word_finish_drop: got %b expected 0", req_finish);
    end
    ack_delay = 0;
    $display("wr_word addr=1234 wdata=beef latency=%0d", lat);
  endtask

  task automatic test_ld_filt();
    int lat; bit ok;
    logic [N*DW-1:0] exp_filt;
    fb_t f;
    fill_ram(1);
    fb_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(AW'(150 + i));
      exp_filt[i*DW +: DW] = pat(1, AW'(150 + i));
    end
    run_req(2'd2, 16'd150, 16'd999, 16'd3, 16'd0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != 27) begin
      errors++;
      $display("FAIL ld_filt_latency: got %0d (finished=%0d) expected 27", lat, ok);
    end
    check_reads("ld_filt");
    checks++;
    if (fb_q.size() != 1) begin
      errors++;
      $display("FAIL ld_filt_fb_count: got %0d pushes expected 1", fb_q.size());
    end else begin
      f = fb_q.pop_front();
      checks++;
      if (f.sel !== 1'b0 || f.index !== 16'd3 || f.filter !== exp_filt) begin
        errors++;
        $display("FAIL ld_filt_fb: got sel %b index %0d filter %h expected sel 0 index 3 filter %h",
                 f.sel, f.index, f.filter, exp_filt);
      end
    end
    fb_q.delete();
    checks++;
    if (win_data !== last_win) begin
      errors++;
      $display("FAIL ld_filt_win_stable: got %h expected %h", win_data, last_win);
    end
    $display("ld_filt addr=150 index=3 latency=%0d", lat);
  endtask

  task automatic test_ld_bias();
    int lat; bit ok;
    fb_t f;
    logic [DW-1:0] eb;
    eb = pat(1, 16'd50557);
    exp_q.push_back(16'd50557);
    run_req(2'd3, 16'd50550, 16'd0, 16'd7, 16'd0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != 3) begin
      errors++;
      $display("FAIL ld_bias_latency: got %0d (finished=%0d) expected 3", lat, ok);
    end
    check_reads("ld_bias");
    checks++;
    if (fb_q.size() != 1) begin
      errors++;
      $display("FAIL ld_bias_fb_count: got %0d pushes expected 1", fb_q.size());
    end else begin
      f = fb_q.pop_front();
      checks++;
      if (f.sel !== 1'b1 || f.index !== 16'd7 || f.bias !== eb) begin
        errors++;
        $display("FAIL ld_bias_fb: got sel %b index %0d bias %h expected sel 1 index 7 bias %h",
                 f.sel, f.index, f.bias, eb);
      end
    end
    fb_q.delete();
    $display("ld_bias addr=50550 index=7 latency=%0d", lat);
  endtask

  task automatic test_wrap_hold();
    int lat; bit ok; int held;
    logic [N*DW-1:0] exp_win;
    logic [AW-1:0] a;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        a = AW'(16'hFFFE + r + c);
        exp_q.push_back(a);
        exp_win[(r*K+c)*DW +: DW] = pat(pattern, a);
      end
    run_req(2'd0, 16'hFFFE, 16'd1, 16'd0, 16'd0, 1'b1, lat, ok);
    checks++;
    if (!ok || lat != 26) begin
      errors++;
      $display("FAIL wrap_latency: got %0d (finished=%0d) expected 26", lat, ok);
    end
    check_reads("wrap");
    checks++;
    if (win_data !== exp_win) begin
      errors++;
      $display("FAIL wrap_data: got %h expected %h", win_data, exp_win);
    end
    held = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_finish === 1'b1 && mem_en === 1'b0) held++;
    end
    checks++;
    if (held != 6 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_no_retrigger: got %0d held cycles %0d accesses expected 6 and 0", held, obs_q.size());
    end
    req_start = 1'b0;
    @(negedge clk);
    $display("rd_win addr=fffe stride=1 latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; bit reached;
    logic [2*N*DW+3*DW+AW+16+5-1:0] all_out;
    logic [N*DW-1:0] exp_win;
    @(negedge clk);
    req_op = 2'd0; req_addr = 16'd200; req_stride = 16'd10; req_start = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obs_q.size() >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d accesses expected 10", obs_q.size());
    end
    reset = 1'b1;
    req_start = 1'b0;
    @(negedge clk);
    all_out = {req_finish, mem_en, mem_we, mem_addr, mem_wdata, fb_we, fb_sel, fb_index,
               fb_filter, fb_bias, win_data};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %0d set bits expected 0", $countones(all_out));
    end
    reset = 1'b0;
    obs_q.delete();
    fb_q.delete();
    exp_q.delete();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        exp_q.push_back(AW'(300 + 7 * r + c));
        exp_win[(r*K+c)*DW +: DW] = pat(pattern, AW'(300 + 7 * r + c));
      end
    run_req(2'd0, 16'd300, 16'd7, 16'd0, 16'd0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != 26) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d (finished=%0d) expected 26", lat, ok);
    end
    check_reads("reset_mid");
    checks++;
    if (win_data !== exp_win) begin
      errors++;
      $display("FAIL reset_mid_data: got %h expected %h", win_data, exp_win);
    end
    @(negedge clk);
    $display("reset mid-transfer then rd_win addr=300 stride=7 latency=%0d", lat);
  endtask

  initial begin
    test_reset();
    test_rd_win();
    test_wr_word();
    test_ld_filt();
    test_ld_bias();
    test_wrap_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
